// File: rtl/reg_no_encoder_pkg.sv
// Shared types and sizes for the register-number encoder and its round-robin picker.
package reg_no_encoder_pkg;

  localparam int N_REGS = 4;
  localparam int REG_W  = 2;
  localparam int CNT_W  = 8;

  typedef logic [REG_W-1:0] reg_no_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [N_REGS-1:0] onehot(input reg_no_t idx);
    logic [N_REGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin first-one finder over four lines, searching from ptr upward with wrap.
module rr_pick4
  import reg_no_encoder_pkg::*;
(
  input  logic [N_REGS-1:0] vec,
  input  reg_no_t           ptr,
  output logic              found,
  output reg_no_t           idx
);

  // Walk the offsets from farthest to nearest so the closest set bit to ptr wins.
  // NOTE: every output of a combinational block gets a default first; otherwise a latch is inferred.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_REGS - 1; k >= 0; k--) begin
      if (vec[ptr + reg_no_t'(k)]) begin
        found = 1'b1;
        idx   = ptr + reg_no_t'(k);
      end
    end
  end

endmodule

// File: rtl/reg_no_encoder.sv
// Collects one-hot register requests and hands out one encoded register number at a time
// on a valid/ready handshake, round-robin between pending requests.
module reg_no_encoder
  import reg_no_encoder_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REGS-1:0]  req,
  output logic [REG_W-1:0]   reg_no,
  output logic               reg_valid,
  input  logic               reg_ready,
  output logic [N_REGS-1:0]  pending,
  output logic [CNT_W-1:0]   merge_cnt
);

  state_t            state, state_next;
  reg_no_t           ptr, ptr_next;
  reg_no_t           reg_no_next;
  logic              accept;
  logic [N_REGS-1:0] clr;
  logic [N_REGS-1:0] cand;
  logic [N_REGS-1:0] merge_hit;
  logic [2:0]        merge_add;
  logic [CNT_W:0]    merge_sum;
  logic              idle_found, next_found;
  reg_no_t           idle_idx, next_idx;

  assign reg_valid = (state == HOLD);
  assign accept    = reg_valid && reg_ready;
  assign clr       = accept ? onehot(reg_no) : '0;
  // Selection only looks at already-latched requests, never the same-cycle req.
  assign cand      = pending & ~clr;
  assign merge_hit = req & cand;

  rr_pick4 u_pick_idle (
    .vec   (pending),
    .ptr   (ptr),
    .found (idle_found),
    .idx   (idle_idx)
  );

  rr_pick4 u_pick_next (
    .vec   (cand),
    .ptr   (reg_no + reg_no_t'(1)),
    .found (next_found),
    .idx   (next_idx)
  );

  always_comb begin
    state_next  = state;
    reg_no_next = reg_no;
    ptr_next    = ptr;
    unique case (state)
      IDLE: begin
        if (idle_found) begin
          reg_no_next = idle_idx;
          state_next  = HOLD;
        end
      end
      HOLD: begin
        if (reg_ready) begin
          ptr_next = reg_no + reg_no_t'(1);
          if (next_found) reg_no_next = next_idx;
          else            state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    merge_add = '0;
    for (int i = 0; i < N_REGS; i++) merge_add = merge_add + 3'(merge_hit[i]);
  end

  assign merge_sum = {1'b0, merge_cnt} + (CNT_W+1)'(merge_add);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      reg_no    <= '0;
      ptr       <= '0;
      pending   <= '0;
      merge_cnt <= '0;
    end else begin
      state     <= state_next;
      reg_no    <= reg_no_next;
      ptr       <= ptr_next;
      pending   <= cand | req;
      merge_cnt <= merge_sum[CNT_W] ? {CNT_W{1'b1}} : merge_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_reg_no_encoder.sv
// Self-checking bench: directed scenarios with literal expectations plus random traffic
// compared every cycle against a behavioural model of the request/grant rules.
module tb_reg_no_encoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] reg_no;
  logic       reg_valid;
  logic       reg_ready;
  logic [3:0] pending;
  logic [7:0] merge_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  reg_no_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .reg_no    (reg_no),
    .reg_valid (reg_valid),
    .reg_ready (reg_ready),
    .pending   (pending),
    .merge_cnt (merge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a set of waiting registers, a grant slot and a rotating start point.
  bit [3:0] m_pend  = '0;
  bit       m_valid = 1'b0;
  int       m_reg   = 0;
  int       m_ptr   = 0;
  int       m_cnt   = 0;

  function automatic int rr_first(input bit [3:0] v, input int start);
    for (int k = 0; k < 4; k++) begin
      if (v[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0; m_valid = 1'b0; m_reg = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      bit       acc;
      bit [3:0] left;
      int       pick;
      acc  = m_valid && reg_ready;
      left = m_pend;
      if (acc) left[m_reg] = 1'b0;
      for (int i = 0; i < 4; i++)
        if (req[i] && left[i] && m_cnt < 255) m_cnt = m_cnt + 1;
      if (!m_valid) begin
        pick = rr_first(m_pend, m_ptr);
        if (pick >= 0) begin m_valid = 1'b1; m_reg = pick; end
      end else if (acc) begin
        m_ptr = (m_reg + 1) % 4;
        pick  = rr_first(left, m_ptr);
        if (pick >= 0) m_reg = pick;
        else           m_valid = 1'b0;
      end
      m_pend = left | req;
    end
  end

  always @(negedge clk) begin
    check("valid", 32'(reg_valid), 32'(m_valid));
    if (m_valid) check("reg_no", 32'(reg_no), 32'(m_reg));
    check("pending", 32'(pending), 32'(m_pend));
    check("merge_cnt", 32'(merge_cnt), 32'(m_cnt));
  end

  // Apply inputs for one cycle; returns 2 time units after the sampling edge.
  task automatic cyc(input logic [3:0] r, input logic rd);
    req = r; reg_ready = rd;
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; reg_ready = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; reg_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_valid", 32'(reg_valid), 0);
    check("reset_pending", 32'(pending), 0);
    check("reset_cnt", 32'(merge_cnt), 0);
    rst_n = 1'b1;

    // Single request: pending after one edge, valid after the next.
    cyc(4'b0001, 1'b1);
    check("single_pend", 32'(pending), 32'h1);
    check("single_nvalid", 32'(reg_valid), 0);
    cyc(4'b0000, 1'b1);
    check("single_valid", 32'(reg_valid), 1);
    check("single_reg", 32'(reg_no), 0);
    cyc(4'b0000, 1'b1);
    check("single_drop", 32'(reg_valid), 0);
    check("single_clear", 32'(pending), 0);

    // Round robin over all four.
    do_reset();
    cyc(4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0000, 1'b1);
      check("rr_valid", 32'(reg_valid), 1);
      check("rr_reg", 32'(reg_no), 32'(i));
    end
    cyc(4'b0000, 1'b1);
    check("rr_end", 32'(reg_valid), 0);

    // Backpressure: grant held while stalled, late request does not steal it.
    do_reset();
    cyc(4'b0110, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc((i == 2) ? 4'b0001 : 4'b0000, 1'b0);
      check("bp_stable", 32'(reg_no), 1);
    end
    check("bp_pend", 32'(pending), 32'h7);
    cyc(4'b0000, 1'b1); check("bp_order1", 32'(reg_no), 2);
    cyc(4'b0000, 1'b1); check("bp_order2", 32'(reg_no), 0);
    cyc(4'b0000, 1'b1); check("bp_idle", 32'(reg_valid), 0);

    // Set/clear collision on register 2.
    do_reset();
    cyc(4'b1110, 1'b1);
    cyc(4'b0000, 1'b1); check("col_g1", 32'(reg_no), 1);
    cyc(4'b0000, 1'b1); check("col_g2", 32'(reg_no), 2);
    cyc(4'b0100, 1'b1); check("col_g3", 32'(reg_no), 3);
    check("col_pend", 32'(pending), 32'hC);
    cyc(4'b0000, 1'b1); check("col_regrant", 32'(reg_no), 2);
    cyc(4'b0000, 1'b1); check("col_idle", 32'(reg_valid), 0);

    // Merge counter saturation while stalled.
    do_reset();
    cyc(4'b0011, 1'b0);
    for (int i = 0; i < 10; i++) cyc(4'b0011, 1'b0);
    check("merge_20", 32'(merge_cnt), 20);
    for (int i = 0; i < 190; i++) cyc(4'b0011, 1'b0);
    check("merge_sat", 32'(merge_cnt), 255);
    cyc(4'b0011, 1'b0);
    check("merge_nowrap", 32'(merge_cnt), 255);
    check("merge_reg", 32'(reg_no), 0);

    // Asynchronous reset mid-grant.
    do_reset();
    cyc(4'b1000, 1'b0);
    cyc(4'b1000, 1'b0);
    check("ar_reg", 32'(reg_no), 3);
    check("ar_cnt_pre", 32'(merge_cnt), 1);
    rst_n = 1'b0; req = '0;
    #1;
    check("ar_valid", 32'(reg_valid), 0);
    check("ar_reg0", 32'(reg_no), 0);
    check("ar_pend", 32'(pending), 0);
    check("ar_cnt", 32'(merge_cnt), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #2;
    cyc(4'b1111, 1'b1);
    cyc(4'b0000, 1'b1);
    check("ar_first", 32'(reg_no), 0);
    check("ar_first_v", 32'(reg_valid), 1);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
          1'($urandom_range(0, 3) != 0));
    end
    cyc(4'b0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
